fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the character width in bits; legal range 1..16.
REQ-003 Parameter CLK_DIV, default 104, SHALL set clk cycles per UART bit; legal range 2..65535.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 empty  input  1  SHALL be the FIFO empty flag; 1 means no word is available.
REQ-007 q  input  DATA_WIDTH  SHALL be the FIFO read data, valid the cycle after re is sampled high.
REQ-008 re  output  1  SHALL be the FIFO read enable; each high cycle pops exactly one word.
REQ-009 tx  output  1  SHALL be the UART serial line: idle high, 8N1-style framing at DATA_WIDTH bits.
REQ-010 busy  output  1  SHALL be high whenever a character is being fetched or transmitted.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, LATCH, START, DATA and STOP.
REQ-012 In IDLE, re SHALL equal ~empty combinationally (and SHALL be 0 while rst=1); with empty=0 the next state SHALL be LATCH, otherwise IDLE.
REQ-013 In LATCH, for one cycle, q SHALL be captured into a DATA_WIDTH shift register and the next state SHALL be START.
REQ-014 re SHALL be 0 in every state except IDLE, so that exactly one pop occurs per character.
REQ-015 START SHALL drive tx=0 for exactly CLK_DIV cycles, then go to DATA.
REQ-016 DATA SHALL drive DATA_WIDTH bits LSB first, each for exactly CLK_DIV cycles, then go to STOP.
REQ-017 STOP SHALL drive tx=1 for exactly CLK_DIV cycles, then go to IDLE.
REQ-018 tx SHALL be 1 in IDLE and LATCH, and SHALL be registered (glitch-free).
REQ-019 busy SHALL be 0 in IDLE and 1 in LATCH, START, DATA and STOP.
REQ-020 The baud counter SHALL be $clog2(CLK_DIV) bits wide, count 0..CLK_DIV-1, and clear on every state change.
REQ-021 The bit counter SHALL count 0..DATA_WIDTH-1 with no wrap beyond DATA_WIDTH-1.
REQ-022 The pop-to-pop spacing for back-to-back characters SHALL be exactly 2+(DATA_WIDTH+2)*CLK_DIV cycles.
REQ-023 Changes on empty or q outside IDLE and LATCH respectively SHALL be ignored.
REQ-024 With empty held at 1, the block SHALL remain in IDLE indefinitely with re=0 and tx=1.

Reset
REQ-025 While rst=1, the next state SHALL be IDLE, the counters SHALL be 0 and the shift register SHALL be 0.
REQ-026 tx SHALL be 1, busy 0 and re 0 in the cycle after rst is sampled high.
REQ-027 Reset asserted mid-frame SHALL abandon the character with no further pop and no completion of the frame.

Structure
REQ-028 The state encodings and the default CLK_DIV SHALL live in the shared package igloo_uart_pkg.
REQ-029 The baud counter SHALL be a sub-module, baud_gen, with ports clk, rst, clear and tick.
REQ-030 The FSM, bit counter and shift register SHALL stay in fifo_uart_tx.

Verification
REQ-031 Reset then empty=1 for 100 cycles -> re=0, tx=1, busy=0 throughout.
REQ-032 CLK_DIV=4, DATA_WIDTH=8, one word 8'hA5 -> one re pulse; tx = 0, then 1,0,1,0,0,1,0,1, then 1, each for 4 cycles; busy falls after 42 cycles.
REQ-033 Three words 8'h01, 8'h80, 8'hFF queued -> re pulses exactly 42 cycles apart and three correctly decoded frames.
REQ-034 rst pulsed in DATA bit 3 of 8'h55 -> tx=1 and busy=0 the next cycle; no extra re; the next queued word is sent intact.
REQ-035 DATA_WIDTH=16, CLK_DIV=2, word 16'h8001 -> 18 bits at 2 cycles per bit; LSB and MSB are 1, all other data bits are 0.
REQ-036 q changed to 8'h00 during START of an 8'h3C frame -> the transmitted value is still 8'h3C.

Source files
------------

// File: rtl/igloo_uart_pkg.sv
// ============================================================================
//  Module   : igloo_uart_pkg
//  Brief    : Shared UART definitions: FSM state encodings and default bit time.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package igloo_uart_pkg;

   localparam int c_DEFAULT_CLK_DIV = 104;

   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_LATCH = 3'd1;
   localparam logic [2:0] c_ST_START = 3'd2;
   localparam logic [2:0] c_ST_DATA  = 3'd3;
   localparam logic [2:0] c_ST_STOP  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = c_ST_IDLE,
      ST_LATCH = c_ST_LATCH,
      ST_START = c_ST_START,
      ST_DATA  = c_ST_DATA,
      ST_STOP  = c_ST_STOP
   } state_t;

   // A 1-bit character still needs a 1-bit index counter
   function automatic int bit_cnt_width(input int data_width);
      return (data_width > 1) ? $clog2(data_width) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/baud_gen.sv
// ============================================================================
//  Module   : baud_gen
//  Brief    : Free-running bit-time counter with a one-cycle tick every CLK_DIV.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_gen
   import igloo_uart_pkg::*;
#(
   parameter int CLK_DIV = c_DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int                 c_CNT_W = $clog2(CLK_DIV);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

   logic [c_CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clear || tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign tick = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
//  Module   : fifo_uart_tx
//  Brief    : Pops characters from a FIFO and serialises them as start/data/stop.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx
   import igloo_uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = c_DEFAULT_CLK_DIV
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] q,
   output logic                  re,
   output logic                  tx,
   output logic                  busy
);

   localparam int                 c_BIT_W    = bit_cnt_width(DATA_WIDTH);
   localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

   state_t                r_state;
   state_t                w_state_d;
   logic [c_BIT_W-1:0]    r_bit;
   logic [c_BIT_W-1:0]    w_bit_d;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_d;
   logic                  r_tx;
   logic                  w_tx_d;
   logic                  w_tick;
   logic                  w_clear;

   baud_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_baud_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (w_clear),
      .tick  (w_tick)
   );

   always_comb begin
      w_state_d = r_state;
      w_bit_d   = r_bit;
      w_shift_d = r_shift;
      re        = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            re = ~empty & ~rst;
            if (!empty) begin
               w_state_d = ST_LATCH;
            end
         end
         ST_LATCH: begin
            w_shift_d = q;
            w_state_d = ST_START;
         end
         ST_START: begin
            if (w_tick) begin
               w_state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               w_shift_d = r_shift >> 1;
               if (r_bit == c_LAST_BIT) begin
                  w_bit_d   = '0;
                  w_state_d = ST_STOP;
               end else begin
                  w_bit_d = r_bit + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               w_state_d = ST_IDLE;
            end
         end
         default: w_state_d = ST_IDLE;
      endcase

      // Bit time restarts on every state change so each phase lasts CLK_DIV cycles
      w_clear = (w_state_d != r_state);

      // Line level is derived from the next state so tx lands aligned with it
      if (w_state_d == ST_START) begin
         w_tx_d = 1'b0;
      end else if (w_state_d == ST_DATA) begin
         w_tx_d = w_shift_d[0];
      end else begin
         w_tx_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_d;
         r_bit   <= w_bit_d;
         r_shift <= w_shift_d;
         r_tx    <= w_tx_d;
      end
   end

   assign tx   = r_tx;
   assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
//  Module   : tb_fifo_uart_tx
//  Brief    : Self-checking bench for fifo_uart_tx (8-bit/div4 and 16-bit/div2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

   localparam int c_D8  = 4;
   localparam int c_D16 = 2;
   localparam int c_L8  = 2 + (8 + 2) * c_D8;
   localparam int c_L16 = 2 + (16 + 2) * c_D16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        empty8 = 1'b1;
   logic [7:0]  q8 = '0;
   logic        re8, tx8, busy8;
   logic        empty16 = 1'b1;
   logic [15:0] q16 = '0;
   logic        re16, tx16, busy16;

   always #5 clk = ~clk;

   fifo_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(c_D8)) dut8 (
      .clk(clk), .rst(rst), .empty(empty8), .q(q8), .re(re8), .tx(tx8), .busy(busy8)
   );

   fifo_uart_tx #(.DATA_WIDTH(16), .CLK_DIV(c_D16)) dut16 (
      .clk(clk), .rst(rst), .empty(empty16), .q(q16), .re(re16), .tx(tx16), .busy(busy16)
   );

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_re8 = 0;
   bit          chk_en = 1'b0;
   logic [7:0]  fifo8[$];
   logic [15:0] fifo16[$];
   logic [7:0]  mq8[$];
   logic [15:0] mq16[$];
   int          m_pos8 = -1;
   int          m_pos16 = -1;
   logic [7:0]  m_w8 = '0;
   logic [15:0] m_w16 = '0;
   logic        s_re8, s_tx8, s_busy8, s_re16, s_tx16, s_busy16;

   typedef struct {
      logic [7:0] word;
      logic [9:0] frame;   // [0] is the first bit on the line
   } vec_t;
   vec_t tbl[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Line level at position pos (1 = latch cycle) of a character frame
   function automatic logic exp_tx(input int pos, input logic [15:0] w, input int wd, input int d);
      int k;
      if (pos < 2) return 1'b1;
      k = (pos - 2) / d;
      if (k == 0) return 1'b0;
      if (k <= wd) return w[k-1];
      return 1'b1;
   endfunction

   task automatic push8(input logic [7:0] w);
      fifo8.push_back(w);
      mq8.push_back(w);
      empty8 = 1'b0;
   endtask

   task automatic push16(input logic [15:0] w);
      fifo16.push_back(w);
      mq16.push_back(w);
      empty16 = 1'b0;
   endtask

   // Sample/check the current cycle, then advance DUT-side FIFOs and model one clock
   task automatic step();
      logic rst_s;
      #1;
      s_re8 = re8;   s_tx8 = tx8;   s_busy8 = busy8;
      s_re16 = re16; s_tx16 = tx16; s_busy16 = busy16;
      if (s_re8 === 1'b1) n_re8++;
      if (chk_en) begin
         check("re8", s_re8, !rst && m_pos8 < 0 && mq8.size() > 0);
         check("busy8", s_busy8, m_pos8 > 0);
         check("tx8", s_tx8, (m_pos8 > 0) ? exp_tx(m_pos8, 16'(m_w8), 8, c_D8) : 1'b1);
         check("re16", s_re16, !rst && m_pos16 < 0 && mq16.size() > 0);
         check("busy16", s_busy16, m_pos16 > 0);
         check("tx16", s_tx16, (m_pos16 > 0) ? exp_tx(m_pos16, m_w16, 16, c_D16) : 1'b1);
      end
      rst_s = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (s_re8 === 1'b1 && fifo8.size() > 0) q8 = fifo8.pop_front();
      empty8 = (fifo8.size() == 0);
      if (s_re16 === 1'b1 && fifo16.size() > 0) q16 = fifo16.pop_front();
      empty16 = (fifo16.size() == 0);
      if (rst_s) m_pos8 = -1;
      else if (m_pos8 < 0) begin
         if (mq8.size() > 0) begin m_w8 = mq8.pop_front(); m_pos8 = 1; end
      end else begin
         m_pos8++;
         if (m_pos8 == c_L8) m_pos8 = -1;
      end
      if (rst_s) m_pos16 = -1;
      else if (m_pos16 < 0) begin
         if (mq16.size() > 0) begin m_w16 = mq16.pop_front(); m_pos16 = 1; end
      end else begin
         m_pos16++;
         if (m_pos16 == c_L16) m_pos16 = -1;
      end
      @(negedge clk);
   endtask

   // Wait for a pop (unless already seen), then decode the 10 line bits mid-bit
   task automatic capture8(input int clobber, input bit seen, output logic [9:0] frame,
                           output int re_cyc);
      bit got;
      got   = seen;
      frame = '0;
      for (int i = 0; i < 200 && !got; i++) begin
         step();
         got = (s_re8 === 1'b1);
      end
      check("re8_seen", got, 1);
      re_cyc = cyc;
      for (int o = 1; o < c_L8; o++) begin
         if (o == clobber) q8 = 8'h00;
         step();
         for (int b = 0; b < 10; b++)
            if (o == 2 + b * c_D8 + c_D8 / 2) frame[b] = s_tx8;
      end
   endtask

   initial begin
      logic [9:0]  fr;
      logic [17:0] fr16;
      int          rc0, rc1, rc2, gap, n_re_before;
      logic [31:0] w;
      bit          got, done;

      tbl[0] = '{word: 8'hA5, frame: 10'b1101001010};
      tbl[1] = '{word: 8'h01, frame: 10'b1000000010};
      tbl[2] = '{word: 8'h80, frame: 10'b1100000000};
      tbl[3] = '{word: 8'hFF, frame: 10'b1111111110};
      tbl[4] = '{word: 8'h55, frame: 10'b1010101010};
      tbl[5] = '{word: 8'h00, frame: 10'b1000000000};
      tbl[6] = '{word: 8'h3C, frame: 10'b1001111000};

      @(negedge clk);
      rst = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      check("rst_tx8", s_tx8, 1);
      check("rst_busy8", s_busy8, 0);
      check("rst_re8", s_re8, 0);
      rst = 1'b0;

      // Idle with an empty FIFO
      n_re_before = n_re8;
      repeat (100) step();
      check("idle_re_count", n_re8 - n_re_before, 0);
      check("idle_tx8", s_tx8, 1);

      // Single characters from the vector table
      for (int i = 0; i < 6; i++) begin
         push8(tbl[i].word);
         n_re_before = n_re8;
         capture8(-1, 1'b0, fr, rc0);
         check($sformatf("frame_%02h", tbl[i].word), fr, tbl[i].frame);
         step();
         check("busy8_fall", s_busy8, 0);
         check("re8_pulses", n_re8 - n_re_before, 1);
      end

      // Three queued characters back to back
      push8(8'h01); push8(8'h80); push8(8'hFF);
      capture8(-1, 1'b0, fr, rc0);
      check("b2b_frame0", fr, tbl[1].frame);
      capture8(-1, 1'b0, fr, rc1);
      check("b2b_frame1", fr, tbl[2].frame);
      capture8(-1, 1'b0, fr, rc2);
      check("b2b_frame2", fr, tbl[3].frame);
      check("b2b_gap01", rc1 - rc0, c_L8);
      check("b2b_gap12", rc2 - rc1, c_L8);
      repeat (3) step();

      // q changes during START must not corrupt the latched character
      push8(8'h3C);
      capture8(3, 1'b0, fr, rc0);
      check("q_change_frame", fr, tbl[6].frame);
      repeat (3) step();

      // Reset during data bit 3 of 0x55 with 0xC3 queued behind it
      push8(8'h55); push8(8'hC3);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         step();
         got = (s_re8 === 1'b1);
      end
      check("rst_mid_re_seen", got, 1);
      for (int o = 1; o < 2 + 4 * c_D8 + 1; o++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_re_before = n_re8;
      step();
      check("mid_rst_tx8", s_tx8, 1);
      check("mid_rst_busy8", s_busy8, 0);
      check("mid_rst_re8", s_re8, 1);
      capture8(-1, 1'b1, fr, rc0);
      check("after_rst_frame", fr, 10'b1110000110);
      check("after_rst_pops", n_re8 - n_re_before, 1);
      repeat (3) step();

      // 16-bit character at two cycles per bit
      push16(16'h8001);
      got  = 1'b0;
      fr16 = '0;
      for (int i = 0; i < 200 && !got; i++) begin
         step();
         got = (s_re16 === 1'b1);
      end
      check("re16_seen", got, 1);
      for (int o = 1; o < c_L16; o++) begin
         step();
         for (int b = 0; b < 18; b++)
            if (o == 2 + b * c_D16 + c_D16 / 2) fr16[b] = s_tx16;
      end
      check("frame16_8001", fr16, 18'b11000000000000001_0);
      step();
      check("busy16_fall", s_busy16, 0);

      // Random characters at random spacing on both instances
      for (int n = 0; n < 25; n++) begin
         gap = $urandom_range(0, 50);
         repeat (gap) step();
         w = $urandom;
         push8(w[7:0]);
         if (w[16]) push16(w[31:16]);
      end
      done = 1'b0;
      for (int i = 0; i < 4000 && !done; i++) begin
         step();
         done = (m_pos8 < 0) && (m_pos16 < 0) && (mq8.size() == 0) && (mq16.size() == 0);
      end
      check("random_drain", done, 1);
      repeat (5) step();
      check("final_fifo8_empty", fifo8.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
